// File: rtl/timer_counter_pkg.sv
// Shared definitions for the timer_counter block: FSM state encoding,
// register offsets, MODE codes and CTRL bit positions.
package timer_counter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_CNT  = 2'd2,
        ST_INT  = 2'd3
    } state_t;

    localparam logic [1:0] OFF_CTRL   = 2'd0;
    localparam logic [1:0] OFF_PRESET = 2'd1;
    localparam logic [1:0] OFF_COUNT  = 2'd2;
    localparam logic [1:0] OFF_RSVD   = 2'd3;

    localparam logic [1:0] MODE_ONESHOT = 2'd0;
    localparam logic [1:0] MODE_RELOAD  = 2'd1;

    localparam int CTRL_EN_BIT   = 0;
    localparam int CTRL_MODE_LSB = 1;
    localparam int CTRL_MODE_MSB = 2;
    localparam int CTRL_IM_BIT   = 3;

endpackage

// File: rtl/timer_counter.sv
// Memory-mapped 32-bit down-counting timer with one-shot / auto-reload modes
// and a maskable interrupt request.
module timer_counter
    import timer_counter_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] addr,
    input  logic        we,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        irq
);

    logic [3:0]  ctrl_r;
    logic [31:0] preset_r;
    logic [31:0] count_r;
    logic        irq_flag_r;
    state_t      state_r;

    state_t      state_s;
    logic [31:0] count_s;
    logic        flag_set_s;
    logic        flag_clr_s;
    logic        en_clr_s;
    logic        ctrl_wr_s;
    logic        preset_wr_s;
    logic [1:0]  reg_sel_s;
    logic [1:0]  mode_s;
    logic        unused_addr_s;

    assign reg_sel_s     = addr[3:2];
    assign ctrl_wr_s     = we && (reg_sel_s == OFF_CTRL);
    assign preset_wr_s   = we && (reg_sel_s == OFF_PRESET);
    assign mode_s        = ctrl_r[CTRL_MODE_MSB:CTRL_MODE_LSB];
    assign unused_addr_s = ^{addr[31:4], addr[1:0]};

    // Next-state and count update; MODE 1x falls through to one-shot handling.
    always_comb begin
        state_s    = state_r;
        count_s    = count_r;
        flag_set_s = 1'b0;
        flag_clr_s = 1'b0;
        en_clr_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (ctrl_r[CTRL_EN_BIT]) begin
                    state_s = ST_LOAD;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_LOAD: begin
                count_s = preset_r;
                state_s = ST_CNT;
            end
            ST_CNT: begin
                if (!ctrl_r[CTRL_EN_BIT]) begin
                    state_s = ST_IDLE;
                end else if (count_r > 32'd1) begin
                    count_s = count_r - 32'd1;
                end else begin
                    // COUNT of 0 or 1 both terminate here, so COUNT never wraps.
                    count_s    = 32'd0;
                    state_s    = ST_INT;
                    flag_set_s = 1'b1;
                end
            end
            ST_INT: begin
                state_s = ST_IDLE;
                if (mode_s == MODE_RELOAD) begin
                    flag_clr_s = 1'b1;
                end else begin
                    en_clr_s = 1'b1;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // FSM state and running count.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= ST_IDLE;
            count_r <= 32'd0;
        end else begin
            state_r <= state_s;
            count_r <= count_s;
        end
    end

    // CTRL register: a CPU write takes priority over the FSM's EN clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ctrl_r <= 4'd0;
        end else if (ctrl_wr_s) begin
            ctrl_r <= wdata[3:0];
        end else if (en_clr_s) begin
            ctrl_r[CTRL_EN_BIT] <= 1'b0;
        end else begin
            ctrl_r <= ctrl_r;
        end
    end

    // PRESET register; only sampled by the FSM in LOAD.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            preset_r <= 32'd0;
        end else if (preset_wr_s) begin
            preset_r <= wdata;
        end else begin
            preset_r <= preset_r;
        end
    end

    // Interrupt flag: any CTRL write acknowledges it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            irq_flag_r <= 1'b0;
        end else if (ctrl_wr_s) begin
            irq_flag_r <= 1'b0;
        end else if (flag_set_s) begin
            irq_flag_r <= 1'b1;
        end else if (flag_clr_s) begin
            irq_flag_r <= 1'b0;
        end else begin
            irq_flag_r <= irq_flag_r;
        end
    end

    // Register read mux.
    always_comb begin
        rdata = 32'd0;
        case (reg_sel_s)
            OFF_CTRL:   rdata = {28'd0, ctrl_r};
            OFF_PRESET: rdata = preset_r;
            OFF_COUNT:  rdata = count_r;
            OFF_RSVD:   rdata = 32'd0;
            default:    rdata = 32'd0;
        endcase
    end

    assign irq = ctrl_r[CTRL_IM_BIT] & irq_flag_r;

endmodule

// File: tb/tb_timer_counter.sv
// Self-checking bench for timer_counter: register table, directed timing
// sequences, and randomized traffic against a plan-queue reference model.
module tb_timer_counter;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] addr = 32'd0;
    logic        we = 1'b0;
    logic [31:0] wdata = 32'd0;
    logic [31:0] rdata;
    logic        irq;

    int n_tests = 0;
    int n_fail  = 0;

    localparam logic [31:0] A_CTRL   = 32'h0;
    localparam logic [31:0] A_PRESET = 32'h4;
    localparam logic [31:0] A_COUNT  = 32'h8;
    localparam logic [31:0] A_RSVD   = 32'hC;

    timer_counter dut (
        .clk   (clk),
        .reset (reset),
        .addr  (addr),
        .we    (we),
        .wdata (wdata),
        .rdata (rdata),
        .irq   (irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cpu_wr(input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        addr  = a;
        wdata = d;
        we    = 1'b1;
        @(posedge clk);
        #1;
        we = 1'b0;
    endtask

    task automatic rd(input logic [31:0] a, output logic [31:0] v);
        addr = a;
        #1;
        v = rdata;
    endtask

    task automatic do_reset();
        @(negedge clk);
        we    = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    // Reference model: a timer run is a queue of pending actions built from PRESET.
    localparam int ACT_LOAD = 0;
    localparam int ACT_TICK = 1;
    localparam int ACT_INT  = 2;
    logic [3:0]  m_ctrl;
    logic [31:0] m_preset;
    logic [31:0] m_count;
    logic        m_flag;
    int          plan[$];

    function automatic logic [31:0] model_rdata(input logic [31:0] a);
        case (a[3:2])
            2'd0:    return {28'd0, m_ctrl};
            2'd1:    return m_preset;
            2'd2:    return m_count;
            default: return 32'd0;
        endcase
    endfunction

    task automatic model_step(input logic w, input logic [31:0] a, input logic [31:0] d);
        bit          en_clear = 1'b0;
        bit          fset = 1'b0;
        bit          fclr = 1'b0;
        int          act;
        int          steps;
        logic [31:0] nc = m_count;
        if (plan.size() == 0) begin
            if (m_ctrl[0]) plan.push_back(ACT_LOAD);
        end else begin
            act = plan.pop_front();
            if (act == ACT_LOAD) begin
                nc    = m_preset;
                steps = (m_preset == 32'd0) ? 1 : int'(m_preset);
                for (int s = 0; s < steps; s++) plan.push_back(ACT_TICK);
                plan.push_back(ACT_INT);
            end else if (act == ACT_TICK) begin
                if (!m_ctrl[0]) begin
                    plan.delete();
                end else begin
                    nc = (m_count == 32'd0) ? 32'd0 : m_count - 32'd1;
                    if (plan[0] == ACT_INT) fset = 1'b1;
                end
            end else begin
                if (m_ctrl[2:1] == 2'b01) fclr = 1'b1;
                else en_clear = 1'b1;
            end
        end
        m_count = nc;
        if (w && a[3:2] == 2'd0) begin
            m_ctrl = d[3:0];
            m_flag = 1'b0;
        end else begin
            if (en_clear) m_ctrl[0] = 1'b0;
            if (fset) m_flag = 1'b1;
            else if (fclr) m_flag = 1'b0;
        end
        if (w && a[3:2] == 2'd1) m_preset = d;
    endtask

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_irq;
    } vec_t;

    vec_t vecs[15];

    initial begin
        logic [31:0] v;
        logic [31:0] exp_c;
        int          r;
        logic        w;
        logic [31:0] a;
        logic [31:0] d;

        // Register-access table; rdata reflects state before that row's write.
        vecs[0]  = '{1'b0, 32'h0000_0000, 32'h0,         32'h0,         1'b0};
        vecs[1]  = '{1'b0, 32'h0000_0004, 32'h0,         32'h0,         1'b0};
        vecs[2]  = '{1'b0, 32'h0000_0008, 32'h0,         32'h0,         1'b0};
        vecs[3]  = '{1'b0, 32'h0000_000C, 32'h0,         32'h0,         1'b0};
        vecs[4]  = '{1'b1, 32'h0000_0000, 32'hFFFF_FFF6, 32'h0,         1'b0};
        vecs[5]  = '{1'b0, 32'h0000_0000, 32'h0,         32'h6,         1'b0};
        vecs[6]  = '{1'b1, 32'h0000_0004, 32'hDEAD_BEEF, 32'h0,         1'b0};
        vecs[7]  = '{1'b0, 32'h0000_0004, 32'h0,         32'hDEAD_BEEF, 1'b0};
        vecs[8]  = '{1'b1, 32'h0000_0008, 32'h0000_1234, 32'h0,         1'b0};
        vecs[9]  = '{1'b0, 32'h0000_0008, 32'h0,         32'h0,         1'b0};
        vecs[10] = '{1'b1, 32'h0000_000C, 32'hFFFF_FFFF, 32'h0,         1'b0};
        vecs[11] = '{1'b0, 32'h0000_010C, 32'h0,         32'h0,         1'b0};
        vecs[12] = '{1'b0, 32'h0000_00F4, 32'h0,         32'hDEAD_BEEF, 1'b0};
        vecs[13] = '{1'b1, 32'h0000_0000, 32'h0,         32'h6,         1'b0};
        vecs[14] = '{1'b0, 32'h0000_0000, 32'h0,         32'h0,         1'b0};

        do_reset();
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            we    = vecs[i].we;
            addr  = vecs[i].addr;
            wdata = vecs[i].wdata;
            #1;
            check($sformatf("vec%0d_rdata", i), rdata, vecs[i].exp_rdata);
            check($sformatf("vec%0d_irq", i), {31'd0, irq}, {31'd0, vecs[i].exp_irq});
            @(posedge clk);
        end
        @(negedge clk);
        we = 1'b0;

        // One-shot, PRESET=5, CTRL=0x9.
        do_reset();
        cpu_wr(A_PRESET, 32'd5);
        cpu_wr(A_CTRL, 32'h9);
        for (int k = 1; k <= 9; k++) begin
            tick();
            rd(A_COUNT, v);
            exp_c = (k < 2) ? 32'd0 : ((k >= 7) ? 32'd0 : 32'(5 - (k - 2)));
            check($sformatf("oneshot_count_k%0d", k), v, exp_c);
            check($sformatf("oneshot_irq_k%0d", k), {31'd0, irq}, (k >= 7) ? 32'd1 : 32'd0);
        end
        rd(A_CTRL, v);
        check("oneshot_ctrl_en_cleared", v, 32'h8);
        cpu_wr(A_CTRL, 32'h0);
        check("oneshot_irq_ack", {31'd0, irq}, 32'd0);

        // Auto-reload, PRESET=3, CTRL=0xB: 6-cycle period.
        do_reset();
        cpu_wr(A_PRESET, 32'd3);
        cpu_wr(A_CTRL, 32'hB);
        for (int k = 1; k <= 20; k++) begin
            tick();
            check($sformatf("reload_irq_k%0d", k), {31'd0, irq},
                  (k >= 5 && (k - 5) % 6 == 0) ? 32'd1 : 32'd0);
            if (k >= 2) begin
                rd(A_COUNT, v);
                case ((k - 2) % 6)
                    0: exp_c = 32'd3;
                    1: exp_c = 32'd2;
                    2: exp_c = 32'd1;
                    default: exp_c = 32'd0;
                endcase
                check($sformatf("reload_count_k%0d", k), v, exp_c);
            end
        end
        cpu_wr(A_CTRL, 32'h0);

        // Masked one-shot, PRESET=2, CTRL=0x1.
        do_reset();
        cpu_wr(A_PRESET, 32'd2);
        cpu_wr(A_CTRL, 32'h1);
        for (int k = 1; k <= 8; k++) begin
            tick();
            check($sformatf("masked_irq_k%0d", k), {31'd0, irq}, 32'd0);
        end
        rd(A_CTRL, v);
        check("masked_ctrl_after", v, 32'h0);

        // Pause: EN cleared on the edge where COUNT becomes 6.
        do_reset();
        cpu_wr(A_PRESET, 32'd10);
        cpu_wr(A_CTRL, 32'h9);
        repeat (5) tick();
        cpu_wr(A_CTRL, 32'h8);
        for (int k = 0; k < 5; k++) begin
            rd(A_COUNT, v);
            check($sformatf("pause_count_%0d", k), v, 32'd6);
            check($sformatf("pause_irq_%0d", k), {31'd0, irq}, 32'd0);
            tick();
        end

        // PRESET=0 behaves as 1: irq 3 cycles after the write.
        do_reset();
        cpu_wr(A_PRESET, 32'd0);
        cpu_wr(A_CTRL, 32'h9);
        for (int k = 1; k <= 3; k++) begin
            tick();
            check($sformatf("preset0_irq_k%0d", k), {31'd0, irq}, (k == 3) ? 32'd1 : 32'd0);
        end
        tick();
        check("preset0_irq_held", {31'd0, irq}, 32'd1);
        reset = 1'b1;
        rd(A_CTRL, v);
        check("async_reset_irq_drop", {31'd0, irq}, 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // Reset between edges at COUNT=4.
        cpu_wr(A_PRESET, 32'd10);
        cpu_wr(A_CTRL, 32'h9);
        repeat (8) tick();
        rd(A_COUNT, v);
        check("midcount_before_reset", v, 32'd4);
        reset = 1'b1;
        rd(A_CTRL, v);
        check("midcount_reset_ctrl", v, 32'd0);
        check("midcount_reset_irq", {31'd0, irq}, 32'd0);
        rd(A_PRESET, v);
        check("midcount_reset_preset", v, 32'd0);
        rd(A_COUNT, v);
        check("midcount_reset_count", v, 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // PRESET write during CNT only affects the next LOAD.
        cpu_wr(A_PRESET, 32'd6);
        cpu_wr(A_CTRL, 32'h9);
        repeat (3) tick();
        cpu_wr(A_PRESET, 32'd20);
        rd(A_COUNT, v);
        check("prewr_count_k4", v, 32'd4);
        for (int k = 5; k <= 8; k++) begin
            tick();
            rd(A_COUNT, v);
            check($sformatf("prewr_count_k%0d", k), v, 32'(6 - (k - 2)));
            check($sformatf("prewr_irq_k%0d", k), {31'd0, irq}, (k == 8) ? 32'd1 : 32'd0);
        end
        rd(A_PRESET, v);
        check("prewr_preset", v, 32'd20);
        // This write lands on the INT cycle; the CPU value must survive the EN clear.
        cpu_wr(A_CTRL, 32'h9);
        rd(A_CTRL, v);
        check("ctrl_write_wins", v, 32'h9);
        check("ctrl_write_acks_irq", {31'd0, irq}, 32'd0);
        repeat (2) tick();
        rd(A_COUNT, v);
        check("prewr_next_load", v, 32'd20);

        // Randomized traffic against the reference model.
        do_reset();
        m_ctrl   = 4'd0;
        m_preset = 32'd0;
        m_count  = 32'd0;
        m_flag   = 1'b0;
        plan.delete();
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            r = int'($urandom_range(0, 99));
            a = $urandom;
            d = $urandom;
            w = 1'b0;
            if (r < 4) begin
                w = 1'b1;
                a[3:2] = 2'd0;
            end else if (r < 9) begin
                w = 1'b1;
                a[3:2] = 2'd1;
                d = 32'($urandom_range(0, 6));
            end else if (r < 12) begin
                w = 1'b1;
                a[3:2] = (r % 2 == 0) ? 2'd2 : 2'd3;
            end
            addr  = a;
            we    = w;
            wdata = d;
            #1;
            check($sformatf("rand%0d_rdata", i), rdata, model_rdata(a));
            check($sformatf("rand%0d_irq", i), {31'd0, irq}, {31'd0, m_ctrl[3] & m_flag});
            model_step(w, a, d);
        end
        @(negedge clk);
        we = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
